// File: rtl/dma_channel_responder.sv
// rtl/dma_channel_responder.sv - single-channel DMA responder: DREQ/DACK handshake, HREQ/HACK bus arbitration, block move
module dma_channel_responder #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_cnt,
    input  logic          cfg_dir,
    input  logic          DREQ,
    output logic          DACK,
    output logic          HREQ,
    input  logic          HACK,
    output logic [AW-1:0] AB,
    input  logic [DW-1:0] DB_in,
    output logic [DW-1:0] DB_out,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          io_rd,
    output logic          io_wr,
    output logic [7:0]    word_count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic          dir_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_reg   <= '0;
            data_reg   <= '0;
            dir_reg    <= 1'b0;
            word_count <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        addr_reg   <= cfg_addr;
                        word_count <= cfg_cnt;
                        dir_reg    <= cfg_dir;
                    end
                end
                S_READ:  data_reg <= DB_in;
                S_WRITE: begin
                    addr_reg   <= addr_reg + AW'(1);
                    word_count <= word_count - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // A config write in IDLE defers the request check by one cycle so it sees the new count.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!cfg_we && DREQ && (word_count != 8'd0)) state_next = S_REQ;
            S_REQ:   if (HACK) state_next = S_ACK;
            S_ACK:   state_next = S_READ;
            S_READ:  state_next = S_WRITE;
            S_WRITE: begin
                if (word_count == 8'd1)  state_next = S_DONE;
                else if (DREQ && HACK)   state_next = S_READ;
                else                     state_next = S_IDLE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        HREQ   = 1'b0;
        DACK   = 1'b0;
        AB     = '0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        io_rd  = 1'b0;
        io_wr  = 1'b0;
        done   = 1'b0;
        case (state)
            S_REQ: HREQ = 1'b1;
            S_ACK: begin
                HREQ = 1'b1;
                DACK = 1'b1;
            end
            S_READ: begin
                HREQ = 1'b1;
                DACK = 1'b1;
                if (dir_reg) begin
                    mem_rd = 1'b1;
                    AB     = addr_reg;
                end else begin
                    io_rd  = 1'b1;
                end
            end
            S_WRITE: begin
                HREQ = 1'b1;
                DACK = 1'b1;
                if (dir_reg) begin
                    io_wr  = 1'b1;
                end else begin
                    mem_wr = 1'b1;
                    AB     = addr_reg;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign DB_out = data_reg;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_dma_channel_responder.sv
// tb/tb_dma_channel_responder.sv - directed-vector bench for dma_channel_responder
module tb_dma_channel_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_cnt;
    logic       cfg_dir;
    logic       DREQ;
    logic       DACK;
    logic       HREQ;
    logic       HACK;
    logic [7:0] AB;
    logic [7:0] DB_in;
    logic [7:0] DB_out;
    logic       mem_rd, mem_wr, io_rd, io_wr;
    logic [7:0] word_count;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    dma_channel_responder #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cnt(cfg_cnt), .cfg_dir(cfg_dir),
        .DREQ(DREQ), .DACK(DACK), .HREQ(HREQ), .HACK(HACK),
        .AB(AB), .DB_in(DB_in), .DB_out(DB_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .io_rd(io_rd), .io_wr(io_wr),
        .word_count(word_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] a, input logic [7:0] c, input logic d);
        cfg_we = 1'b1; cfg_addr = a; cfg_cnt = c; cfg_dir = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // READ/WRITE pairs for n words; DREQ is released in the WRITE of word drop_at
    task automatic burst_words(input logic [7:0] a0, input int n, input logic dir,
                               input logic [7:0] pat, input logic [7:0] cnt0, input int drop_at);
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            a = a0 + 8'(i);
            d = pat + 8'(i);
            tick();
            n_cmp++; if ({mem_rd, mem_wr, io_rd, io_wr} !== (dir ? 4'b1000 : 4'b0010)) begin n_err++; $display("FAIL read_strobe w%0d got %b exp %b", i, {mem_rd, mem_wr, io_rd, io_wr}, (dir ? 4'b1000 : 4'b0010)); end
            n_cmp++; if (AB !== (dir ? a : 8'h00)) begin n_err++; $display("FAIL read_ab w%0d got %h exp %h", i, AB, (dir ? a : 8'h00)); end
            n_cmp++; if ({HREQ, DACK, busy, done} !== 4'b1110) begin n_err++; $display("FAIL read_ctl w%0d got %b exp 1110", i, {HREQ, DACK, busy, done}); end
            DB_in = d;
            tick();
            DB_in = 8'h00;
            n_cmp++; if ({mem_rd, mem_wr, io_rd, io_wr} !== (dir ? 4'b0001 : 4'b0100)) begin n_err++; $display("FAIL write_strobe w%0d got %b exp %b", i, {mem_rd, mem_wr, io_rd, io_wr}, (dir ? 4'b0001 : 4'b0100)); end
            n_cmp++; if (AB !== (dir ? 8'h00 : a)) begin n_err++; $display("FAIL write_ab w%0d got %h exp %h", i, AB, (dir ? 8'h00 : a)); end
            n_cmp++; if (DB_out !== d) begin n_err++; $display("FAIL write_data w%0d got %h exp %h", i, DB_out, d); end
            n_cmp++; if (word_count !== cnt0 - 8'(i)) begin n_err++; $display("FAIL write_count w%0d got %0d exp %0d", i, word_count, cnt0 - 8'(i)); end
            n_cmp++; if ({HREQ, DACK, done} !== 3'b110) begin n_err++; $display("FAIL write_ctl w%0d got %b exp 110", i, {HREQ, DACK, done}); end
            if (i == drop_at) DREQ = 1'b0;
        end
    endtask

    task automatic req_ack();
        tick();
        n_cmp++; if ({HREQ, DACK, busy} !== 3'b101) begin n_err++; $display("FAIL req_state got %b exp 101", {HREQ, DACK, busy}); end
        tick();
        n_cmp++; if ({HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr} !== 6'b110000) begin n_err++; $display("FAIL ack_state got %b exp 110000", {HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr}); end
    endtask

    task automatic expect_done(input string tag);
        tick();
        n_cmp++; if ({done, HREQ, DACK, busy} !== 4'b1001) begin n_err++; $display("FAIL %s_done got %b exp 1001", tag, {done, HREQ, DACK, busy}); end
        n_cmp++; if (word_count !== 8'd0) begin n_err++; $display("FAIL %s_done_count got %0d exp 0", tag, word_count); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL %s_idle got %b exp 00", tag, {done, busy}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 8'h00; cfg_cnt = 8'd0; cfg_dir = 1'b0;
        DREQ = 1'b0; HACK = 1'b0; DB_in = 8'h00;
        tick(); tick();
        n_cmp++; if ({HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr, busy, done} !== 8'h00) begin n_err++; $display("FAIL reset_ctl got %b exp 0", {HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr, busy, done}); end
        n_cmp++; if ({AB, DB_out, word_count} !== 24'h0) begin n_err++; $display("FAIL reset_regs got %h exp 0", {AB, DB_out, word_count}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mem_to_io();
        configure(8'd65, 8'd7, 1'b1);
        n_cmp++; if ({word_count, busy} !== {8'd7, 1'b0}) begin n_err++; $display("FAIL m2i_cfg got %0d/%b exp 7/0", word_count, busy); end
        DREQ = 1'b1; HACK = 1'b1;
        req_ack();
        burst_words(8'd65, 7, 1'b1, 8'h30, 8'd7, -1);
        expect_done("m2i");
    endtask

    task automatic test_io_to_mem();
        DREQ = 1'b0;
        configure(8'd68, 8'd8, 1'b0);
        DREQ = 1'b1; HACK = 1'b1;
        req_ack();
        burst_words(8'd68, 8, 1'b0, 8'hA0, 8'd8, -1);
        expect_done("i2m");
        DREQ = 1'b0;
    endtask

    task automatic test_late_grant();
        HACK = 1'b0; DREQ = 1'b1;
        configure(8'd20, 8'd2, 1'b1);
        n_cmp++; if (HREQ !== 1'b0) begin n_err++; $display("FAIL late_cfg_defer got %b exp 0", HREQ); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr} !== 6'b100000) begin n_err++; $display("FAIL late_wait c%0d got %b exp 100000", i, {HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr}); end
            cfg_we = (i == 2); cfg_cnt = 8'd99;
        end
        cfg_we = 1'b0;
        n_cmp++; if (word_count !== 8'd2) begin n_err++; $display("FAIL late_cfg_busy got %0d exp 2", word_count); end
        HACK = 1'b1;
        tick();
        n_cmp++; if ({HREQ, DACK, mem_rd} !== 3'b110) begin n_err++; $display("FAIL late_ack got %b exp 110", {HREQ, DACK, mem_rd}); end
        burst_words(8'd20, 2, 1'b1, 8'h55, 8'd2, -1);
        expect_done("late");
        DREQ = 1'b0;
    endtask

    task automatic test_dreq_drop();
        configure(8'd10, 8'd4, 1'b0);
        DREQ = 1'b1; HACK = 1'b1;
        req_ack();
        burst_words(8'd10, 2, 1'b0, 8'h60, 8'd4, 1);
        tick();
        n_cmp++; if ({HREQ, DACK, busy} !== 3'b000) begin n_err++; $display("FAIL drop_idle got %b exp 000", {HREQ, DACK, busy}); end
        n_cmp++; if (word_count !== 8'd2) begin n_err++; $display("FAIL drop_count got %0d exp 2", word_count); end
        tick();
        DREQ = 1'b1;
        req_ack();
        burst_words(8'd12, 2, 1'b0, 8'h70, 8'd2, -1);
        expect_done("drop");
        DREQ = 1'b0;
    endtask

    task automatic test_wrap_disabled();
        configure(8'hFE, 8'd3, 1'b1);
        DREQ = 1'b1; HACK = 1'b1;
        req_ack();
        burst_words(8'hFE, 3, 1'b1, 8'h11, 8'd3, -1);
        expect_done("wrap");
        DREQ = 1'b0;
        configure(8'h40, 8'd0, 1'b1);
        DREQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if ({HREQ, busy} !== 2'b00) begin n_err++; $display("FAIL disabled c%0d got %b exp 00", i, {HREQ, busy}); end
        end
        DREQ = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        configure(8'd30, 8'd5, 1'b1);
        DREQ = 1'b1; HACK = 1'b1;
        req_ack();
        burst_words(8'd30, 1, 1'b1, 8'h22, 8'd5, -1);
        tick();
        DB_in = 8'h99;
        tick();
        n_cmp++; if (io_wr !== 1'b1) begin n_err++; $display("FAIL rst_pre_write got %b exp 1", io_wr); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr, busy, done} !== 8'h00) begin n_err++; $display("FAIL rst_mid_ctl got %b exp 0", {HREQ, DACK, mem_rd, mem_wr, io_rd, io_wr, busy, done}); end
        n_cmp++; if ({AB, DB_out, word_count} !== 24'h0) begin n_err++; $display("FAIL rst_mid_regs got %h exp 0", {AB, DB_out, word_count}); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({HREQ, busy, mem_rd, io_wr} !== 4'b0000) begin n_err++; $display("FAIL rst_after c%0d got %b exp 0000", i, {HREQ, busy, mem_rd, io_wr}); end
        end
        DREQ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mem_to_io();
        test_io_to_mem();
        test_late_grant();
        test_dreq_drop();
        test_wrap_disabled();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_channel_responder.md
# dma_channel_responder

DMA-controller-side endpoint of the IO/DMA request protocol: answers an IO device's DREQ, arbitrates the bus from the processor over HREQ/HACK, acknowledges with DACK, then moves a programmed block of words between memory and the IO device. It sits between the IO devices, the processor bus arbiter and memory in the top-level DMA system. One channel per instance. Each word takes one read cycle and one write cycle through an internal data register.

## Interface
Parameters:
- AW, 8, address bus width
- DW, 8, data bus width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- cfg_we  in  1  load channel config; ignored while busy=1
- cfg_addr  in  AW  start memory address
- cfg_cnt  in  8  words to transfer; 0 = channel disabled
- cfg_dir  in  1  0 = IO→memory, 1 = memory→IO
- DREQ  in  1  IO device transfer request, level
- DACK  out  1  acknowledge to IO device
- HREQ  out  1  bus request to processor
- HACK  in  1  bus grant from processor, level
- AB  out  AW  memory address bus; 0 when not driving
- DB_in  in  DW  read data (from memory or IO, per cfg_dir)
- DB_out  out  DW  write data; equals data_reg
- mem_rd, mem_wr, io_rd, io_wr  out  1 each  one-cycle strobes
- word_count  out  8  remaining words
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when word_count reaches 0

## Operation
- Registers: addr_reg (AW), word_count (8), dir_reg, data_reg (DW), state.
- States: IDLE, REQ, ACK, READ, WRITE, DONE.
- IDLE: HREQ=DACK=0. A cfg_we pulse loads addr_reg, word_count and dir_reg. If DREQ=1 and word_count≠0, go to REQ. DREQ is ignored while word_count=0.
- REQ: HREQ=1. Stay until HACK=1, then go to ACK.
- ACK: HREQ=1, DACK=1. Takes one cycle, then go to READ.
- READ (HREQ=DACK=1):
  - dir=0: io_rd=1.
  - dir=1: mem_rd=1 and AB=addr_reg.
  - data_reg ← DB_in at the end of the cycle.
- WRITE (HREQ=DACK=1):
  - dir=0: mem_wr=1 and AB=addr_reg.
  - dir=1: io_wr=1.
  - DB_out=data_reg.
  - At the edge: addr_reg ← addr_reg+1 (mod 2^AW, so 0xFF wraps to 0x00) and word_count ← word_count−1.
- After WRITE:
  - If the new count is 0, go to DONE.
  - Else if DREQ=1 and HACK=1, go to READ (burst continues).
  - Else go to IDLE, releasing HREQ/DACK. The remaining count and address are kept. A later DREQ resumes at REQ.
- DONE: done=1 for one cycle, HREQ=DACK=0, then go to IDLE.
- HACK dropping during READ/WRITE does not abort: the current word completes, then the block follows the after-WRITE rule.
- A cfg_we pulse in the same cycle as a DREQ in IDLE: config loads first; the request is evaluated against the new count on the next cycle.

## Timing
- Reset (rst_n=0 at an edge) forces, from that edge:
  - state=IDLE, HREQ=DACK=0, AB=0, DB_out=0, all strobes 0, busy=0, done=0.
  - word_count=0, addr_reg=0, data_reg=0, dir_reg=0.
- A mid-transfer reset aborts immediately; no partial strobe follows.
- DREQ→HREQ: 1 cycle. HACK→DACK: 1 cycle. DACK→first strobe: 1 cycle.
- Block of N words with DREQ and HACK held high: 2N+3 cycles from the DREQ sample to the done pulse.
  - Per word: 2 cycles (READ, WRITE).
  - Overhead: REQ, ACK and DONE take 1 cycle each.
- Strobes are mutually exclusive and at most one is high per cycle.
- AB is nonzero only in the memory-access cycle.

## Test plan
- Memory→IO block: cfg_addr=65, cfg_cnt=7, dir=1, DREQ and HACK held high.
  - mem_rd at AB=65..71, interleaved with io_wr.
  - word_count falls 7→0; done pulses at cycle 17; HREQ and DACK drop with done.
- IO→memory block: cfg_addr=68, cfg_cnt=8, dir=0; IO supplies DB_in=0xA0+i.
  - mem_wr at AB=68..75 with DB_out=0xA0..0xA7; done at cycle 19.
- Late grant: hold HACK=0 for 5 cycles after DREQ.
  - HREQ stays 1 in REQ; DACK and strobes stay 0; the transfer starts 2 cycles after HACK rises.
- DREQ drop: cfg_cnt=4; deassert DREQ after the 2nd WRITE.
  - Block returns to IDLE with word_count=2 and HREQ=0.
  - Re-asserting DREQ resumes at AB=start+2 and finishes with done.
- Wrap and disabled channel:
  - cfg_addr=0xFE, cnt=3: accesses at AB=FE, FF, 00.
  - cfg_cnt=0 with DREQ=1 for 10 cycles: HREQ stays 0.
- Reset mid-burst: rst_n=0 during WRITE of word 2.
  - All outputs are 0 on the next edge.
  - After release, DREQ gives no activity until a new cfg_we.
